// File: rtl/mat_mult_pkg.sv
// Shared types and helpers for the sequential NxN matrix multiplier.
// Packing puts element [0][0] in the MSBs; the accumulator is sized so no MAC sequence can overflow.
package mat_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int acc_width(input int n, input int ew);
    return 2 * ew + $clog2(n) + 1;
  endfunction

  // LSB position of element [row][col] in a row-major vector of w-bit elements
  function automatic int elem_lsb(input int n, input int w, input int row, input int col);
    return (n * n - 1 - (row * n + col)) * w;
  endfunction

endpackage

// File: rtl/mat_mac.sv
// One multiply-add step: sum = acc + a*b, operands sign- or zero-extended to the accumulator width.
// Purely combinational; no handshake, the parent sequences it.
module mat_mac #(
  parameter int EW = 8,
  parameter int AW = 18
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  input  logic          is_signed,
  input  logic [AW-1:0] acc,
  output logic [AW-1:0] sum
);

  logic [AW-1:0] a_ext;
  logic [AW-1:0] b_ext;
  logic [AW-1:0] prod;

  // Low AW bits of the product are exact in two's complement since AW > 2*EW
  assign a_ext = {{(AW-EW){is_signed & a[EW-1]}}, a};
  assign b_ext = {{(AW-EW){is_signed & b[EW-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + prod;

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential NxN matrix multiply, one MAC per cycle; output_valid rises N^3+1 cycles after accept.
// Operands accepted only in IDLE; Res and output_valid hold in DONE until output_ready.
module mat_mult_seq
  import mat_mult_pkg::*;
#(
  parameter int N   = 2,
  parameter int EW  = 8,
  parameter int RW  = 16,
  parameter int SAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [N*N*EW-1:0] A,
  input  logic [N*N*EW-1:0] B,
  input  logic              is_signed,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [N*N*RW-1:0] Res,
  output logic              busy
);

  localparam int AW = acc_width(N, EW);
  localparam int XW = ((AW > RW) ? AW : RW) + 1;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t              state;
  logic [N*N*EW-1:0]   a_q;
  logic [N*N*EW-1:0]   b_q;
  logic                sgn_q;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       mac_sum;
  logic [IW-1:0]       i;
  logic [IW-1:0]       j;
  logic [IW-1:0]       k;
  logic [EW-1:0]       a_el;
  logic [EW-1:0]       b_el;
  logic [N*N*RW-1:0]   res;

  assign a_el = a_q[elem_lsb(N, EW, int'(i), int'(k)) +: EW];
  assign b_el = b_q[elem_lsb(N, EW, int'(k), int'(j)) +: EW];
  assign Res  = res;

  mat_mac #(.EW(EW), .AW(AW)) u_mac (
    .a         (a_el),
    .b         (b_el),
    .is_signed (sgn_q),
    .acc       (acc),
    .sum       (mac_sum)
  );

  // Widen to XW so both signed and unsigned limits compare correctly as signed values
  function automatic logic [RW-1:0] clamp(input logic [AW-1:0] v, input logic sgn);
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    x  = sgn ? {{(XW-AW){v[AW-1]}}, v} : {{(XW-AW){1'b0}}, v};
    hi = {{(XW-RW){1'b0}}, {RW{1'b1}}};
    lo = '0;
    if (sgn) begin
      hi = {{(XW-RW+1){1'b0}}, {(RW-1){1'b1}}};
      lo = ~hi;
    end
    if (SAT == 0) return x[RW-1:0];
    if (x > hi) return hi[RW-1:0];
    if (x < lo) return lo[RW-1:0];
    return x[RW-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
      busy         <= 1'b0;
      res          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sgn_q        <= 1'b0;
      acc          <= '0;
      i            <= '0;
      j            <= '0;
      k            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (input_valid) begin
            a_q         <= A;
            b_q         <= B;
            sgn_q       <= is_signed;
            acc         <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            state       <= RUN;
            input_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (k == LAST) begin
            res[elem_lsb(N, RW, int'(i), int'(j)) +: RW] <= clamp(mac_sum, sgn_q);
            acc <= '0;
            k   <= '0;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i            <= '0;
                state        <= DONE;
                output_valid <= 1'b1;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            acc <= mac_sum;
            k   <= k + 1'b1;
          end
        end
        DONE: begin
          if (output_ready) begin
            state        <= IDLE;
            output_valid <= 1'b0;
            input_ready  <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          output_valid <= 1'b0;
          input_ready  <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
